p2p_link_arbiter: RTL and testbench

- Shares one point-to-point message link (MSG_W-bit request out, MSG_W-bit response back) between N_REQ requesters.
- Requesters are A-style senders. The far end is a B-style responder.
- Runs one transaction at a time: arbitrate, send one message, wait for the response or a timeout, return the response to the granted requester.
- Sits between the requester modules and the single physical link in the interconnect testbench hierarchy.

---
 rtl/p2p_link_arbiter.sv | 122 ++++++++++++
 tb/tb_p2p_link_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/p2p_link_arbiter.sv
// Shares one point-to-point message link among N_REQ requesters, one transaction at a time.
// Define FIXED_PRIORITY_EN for lowest-index-wins arbitration; round-robin otherwise.
module p2p_link_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MSG_W   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*MSG_W-1:0]   msg_in,
    output logic [N_REQ-1:0]         grant,
    output logic [MSG_W-1:0]         link_out,
    output logic                     link_valid,
    input  logic [MSG_W-1:0]         link_resp,
    input  logic                     link_resp_valid,
    output logic [MSG_W-1:0]         resp_out,
    output logic [N_REQ-1:0]         resp_valid,
    output logic                     timeout_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               timeout_flag;
    logic               timeout_hit;
    logic [IDX_W-1:0]   win_idx;

`ifndef FIXED_PRIORITY_EN
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   owner;
`endif

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Winner selection; descending scan so the closest eligible index is assigned last.
    always_comb begin
        win_idx = '0;
`ifdef FIXED_PRIORITY_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) win_idx = IDX_W'(i);
        end
`else
        for (int off = N_REQ; off >= 1; off--) begin
            if (req[(int'(last) + off) % N_REQ])
                win_idx = IDX_W'((int'(last) + off) % N_REQ);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req) next_state = SEND;
            SEND:    next_state = WAIT;
            WAIT:    if (link_resp_valid || timeout_hit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction datapath: message and owner are latched at the grant edge and held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant        <= '0;
            link_out     <= '0;
            resp_out     <= '0;
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
`ifndef FIXED_PRIORITY_EN
            last         <= IDX_W'(N_REQ - 1);
            owner        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant    <= N_REQ'(1) << win_idx;
                        link_out <= msg_in[win_idx*MSG_W +: MSG_W];
`ifndef FIXED_PRIORITY_EN
                        owner    <= win_idx;
`endif
                    end
                end
                SEND: wait_cnt <= '0;
                WAIT: begin
                    if (link_resp_valid) begin
                        resp_out <= link_resp;
                    end else if (timeout_hit) begin
                        resp_out     <= '0;
                        timeout_flag <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    grant        <= '0;
                    timeout_flag <= 1'b0;
`ifndef FIXED_PRIORITY_EN
                    last         <= owner;
`endif
                end
                default: ;
            endcase
        end
    end

    assign link_valid  = (state == SEND);
    assign resp_valid  = (state == DONE) ? grant : '0;
    assign timeout_err = (state == DONE) && timeout_flag;

endmodule

// File: tb/tb_p2p_link_arbiter.sv
// Directed self-checking bench for p2p_link_arbiter (N_REQ=4, MSG_W=4, TIMEOUT=8).
module tb_p2p_link_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] msg_in;
    logic [3:0]  grant;
    logic [3:0]  link_out;
    logic        link_valid;
    logic [3:0]  link_resp;
    logic        link_resp_valid;
    logic [3:0]  resp_out;
    logic [3:0]  resp_valid;
    logic        timeout_err;

    int vectors;
    int miscompares;

    p2p_link_arbiter #(.N_REQ(4), .MSG_W(4), .TIMEOUT(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .msg_in          (msg_in),
        .grant           (grant),
        .link_out        (link_out),
        .link_valid      (link_valid),
        .link_resp       (link_resp),
        .link_resp_valid (link_resp_valid),
        .resp_out        (resp_out),
        .resp_valid      (resp_valid),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] m,
                                 input logic rv, input logic [3:0] rd);
        req             = r;
        msg_in          = m;
        link_resp_valid = rv;
        link_resp       = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [3:0] exp_grant;
        logic [3:0] exp_msg;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyStimulus(4'b0000, 16'h0000, 1'b0, 4'h0);
        repeat (2) tick();
        rst_n = 1'b1;

        checkOutput("rst_grant", 16'(grant), 16'h0);
        checkOutput("rst_link_out", 16'(link_out), 16'h0);
        checkOutput("rst_link_valid", 16'(link_valid), 16'h0);
        checkOutput("rst_resp_valid", 16'(resp_valid), 16'h0);
        checkOutput("rst_timeout_err", 16'(timeout_err), 16'h0);

        // Single transaction, prompt response
        applyStimulus(4'b0001, 16'h000A, 1'b0, 4'h0);
        tick();
        checkOutput("t1_grant", 16'(grant), 16'h1);
        checkOutput("t1_link_out", 16'(link_out), 16'hA);
        checkOutput("t1_link_valid", 16'(link_valid), 16'h1);
        applyStimulus(4'b0000, 16'h000A, 1'b1, 4'h5);
        tick();
        checkOutput("t1_link_valid_pulse", 16'(link_valid), 16'h0);
        checkOutput("t1_no_early_resp", 16'(resp_valid), 16'h0);
        tick();
        checkOutput("t1_resp_valid", 16'(resp_valid), 16'h1);
        checkOutput("t1_resp_out", 16'(resp_out), 16'h5);
        checkOutput("t1_timeout_err", 16'(timeout_err), 16'h0);
        applyStimulus(4'b0000, 16'h000A, 1'b0, 4'h0);
        tick();
        checkOutput("t1_idle_grant", 16'(grant), 16'h0);
        checkOutput("t1_idle_resp_valid", 16'(resp_valid), 16'h0);

        // Fresh pointer, all requesters held
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        applyStimulus(4'b1111, 16'h4321, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) begin
`ifdef FIXED_PRIORITY_EN
            exp_grant = 4'b0001;
            exp_msg   = 4'h1;
`else
            exp_grant = 4'b0001 << (i % 4);
            exp_msg   = 4'((i % 4) + 1);
`endif
            tick();
            checkOutput($sformatf("rr%0d_grant", i), 16'(grant), 16'(exp_grant));
            checkOutput($sformatf("rr%0d_link_out", i), 16'(link_out), 16'(exp_msg));
            applyStimulus(4'b1111, 16'h4321, 1'b1, 4'(i + 6));
            tick();
            tick();
            checkOutput($sformatf("rr%0d_resp_valid", i), 16'(resp_valid), 16'(exp_grant));
            checkOutput($sformatf("rr%0d_resp_out", i), 16'(resp_out), 16'(i + 6));
            applyStimulus(4'b1111, 16'h4321, 1'b0, 4'h0);
            tick();
            checkOutput($sformatf("rr%0d_idle_grant", i), 16'(grant), 16'h0);
        end

        // Timeout with no response
        applyStimulus(4'b0100, 16'h4321, 1'b0, 4'h0);
        tick();
        checkOutput("to_grant", 16'(grant), 16'h4);
        applyStimulus(4'b0000, 16'h4321, 1'b0, 4'h0);
        tick();
        repeat (7) tick();
        checkOutput("to_still_waiting", 16'(resp_valid), 16'h0);
        tick();
        checkOutput("to_resp_valid", 16'(resp_valid), 16'h4);
        checkOutput("to_resp_out", 16'(resp_out), 16'h0);
        checkOutput("to_timeout_err", 16'(timeout_err), 16'h1);
        tick();
        checkOutput("to_idle_grant", 16'(grant), 16'h0);
        checkOutput("to_err_pulse", 16'(timeout_err), 16'h0);

        // Response on the final WAIT cycle beats the timeout
        applyStimulus(4'b0001, 16'h000B, 1'b0, 4'h0);
        tick();
        checkOutput("late_grant", 16'(grant), 16'h1);
        applyStimulus(4'b0000, 16'h000B, 1'b0, 4'h0);
        tick();
        repeat (7) tick();
        applyStimulus(4'b0000, 16'h000B, 1'b1, 4'h3);
        tick();
        checkOutput("late_resp_valid", 16'(resp_valid), 16'h1);
        checkOutput("late_resp_out", 16'(resp_out), 16'h3);
        checkOutput("late_timeout_err", 16'(timeout_err), 16'h0);
        tick();
        tick();
        checkOutput("idle_resp_ignored_valid", 16'(resp_valid), 16'h0);
        checkOutput("idle_resp_ignored_grant", 16'(grant), 16'h0);
        applyStimulus(4'b0000, 16'h000B, 1'b0, 4'h0);

        // Owner drops req mid-transaction; message latched at grant
        applyStimulus(4'b0010, 16'h00D0, 1'b0, 4'h0);
        tick();
        checkOutput("drop_grant", 16'(grant), 16'h2);
        checkOutput("drop_link_out", 16'(link_out), 16'hD);
        applyStimulus(4'b0010, 16'h00E0, 1'b0, 4'h0);
        tick();
        checkOutput("drop_msg_latched", 16'(link_out), 16'hD);
        applyStimulus(4'b0000, 16'h00E0, 1'b0, 4'h0);
        tick();
        applyStimulus(4'b0000, 16'h00E0, 1'b1, 4'hC);
        tick();
        checkOutput("drop_resp_valid", 16'(resp_valid), 16'h2);
        checkOutput("drop_resp_out", 16'(resp_out), 16'hC);
        applyStimulus(4'b0000, 16'h00E0, 1'b0, 4'h0);
        tick();

        // Asynchronous reset during WAIT
        applyStimulus(4'b1000, 16'h7000, 1'b0, 4'h0);
        tick();
        checkOutput("ar_grant", 16'(grant), 16'h8);
        applyStimulus(4'b0000, 16'h7000, 1'b0, 4'h0);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_grant_cleared", 16'(grant), 16'h0);
        checkOutput("ar_link_out_cleared", 16'(link_out), 16'h0);
        checkOutput("ar_resp_out_cleared", 16'(resp_out), 16'h0);
        checkOutput("ar_resp_valid", 16'(resp_valid), 16'h0);
        rst_n = 1'b1;
        applyStimulus(4'b0110, 16'h0290, 1'b0, 4'h0);
        tick();
        checkOutput("ar_ptr_grant", 16'(grant), 16'h2);
        checkOutput("ar_ptr_link_out", 16'(link_out), 16'h9);
        applyStimulus(4'b0000, 16'h0290, 1'b1, 4'h1);
        tick();
        tick();
        checkOutput("ar_after_resp_valid", 16'(resp_valid), 16'h2);
        applyStimulus(4'b0000, 16'h0290, 1'b0, 4'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
